gemm_idx_gen: RTL and testbench

Sequential GEMM index generator for the GEMM core. It accepts one 128-bit GEMM instruction, walks the `iter_out × iter_in × [uop_bgn, uop_end)` loop nest, and fetches each micro-op from the synchronous uop memory. For every micro-op it emits one accumulator/input/weight index triple on a valid/ready stream into the tensor-read front end. Index widths are parametrised, and an optional bounds check flags out-of-range indices.

---
 rtl/gemm_idx_gen.sv | 186 ++++++++++++++++++
 tb/tb_gemm_idx_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_idx_gen.sv
// GEMM index generator: walks iter_out x iter_in x [uop_bgn, uop_end), fetches uops and
// streams dst/src/wgt index triples. Define GEMM_IDX_BOUND_CHECK_EN for the overflow flag.
module gemm_idx_gen #(
    parameter int ACC_W  = 11,
    parameter int INP_W  = 11,
    parameter int WGT_W  = 10,
    parameter int UOP_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              insn_valid,
    output logic              insn_ready,
    input  logic [127:0]      insn,
    output logic              uop_rd_en,
    output logic [UOP_AW-1:0] uop_addr,
    input  logic [31:0]       uop_data,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic [ACC_W-1:0]  dst_idx,
    output logic [INP_W-1:0]  src_idx,
    output logic [WGT_W-1:0]  wgt_idx,
    output logic              idx_reset,
    output logic              idx_last,
    output logic              done,
    output logic              idx_err
);
    localparam int SW = 26;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state, state_nx;

    // latched instruction; factor/base lanes are 0=dst, 1=src, 2=wgt
    logic               rr;
    logic               empty;
    logic [13:0]        u_bgn, u_end, n_out, n_in;
    logic [2:0][SW-1:0] f_out, f_in;

    logic [13:0]        u, o, i;
    logic [2:0][SW-1:0] base_o, base;

    logic               s1_vld, s1_fresh, s1_last;
    logic [31:0]        s1_data;
    logic [2:0][SW-1:0] s1_base;

    logic               s2_en, issue, u_wrap, i_wrap, o_wrap;
    logic [31:0]        cur_data;
    logic [2:0][SW-1:0] sum;
    logic               err_hit;

    assign u_wrap = (u + 14'd1 == u_end);
    assign i_wrap = (i + 14'd1 == n_in);
    assign o_wrap = (o + 14'd1 == n_out);

    assign s2_en     = !idx_valid || idx_ready;
    assign issue     = (state == RUN) && !empty && (!s1_vld || s2_en) && !rst;
    assign uop_rd_en = issue;
    assign uop_addr  = issue ? u[UOP_AW-1:0] : '0;

    // the memory only presents data for one cycle, so a stalled S1 keeps its own copy
    assign cur_data = s1_fresh ? uop_data : s1_data;
    assign sum[0]   = s1_base[0] + SW'(cur_data[10:0]);
    assign sum[1]   = s1_base[1] + SW'(cur_data[21:11]);
    assign sum[2]   = s1_base[2] + SW'(cur_data[31:22]);

`ifdef GEMM_IDX_BOUND_CHECK_EN
    assign err_hit = (sum[0][SW-1:ACC_W] != '0) || (sum[1][SW-1:INP_W] != '0) ||
                     (sum[2][SW-1:WGT_W] != '0);
`else
    logic unused_sum_hi;
    assign err_hit       = 1'b0;
    assign unused_sum_hi = ^{sum[0][SW-1:ACC_W], sum[1][SW-1:INP_W], sum[2][SW-1:WGT_W]};
`endif

    logic unused_insn;
    assign unused_insn = ^{insn[6:0], insn[127]};

    // emptiness is judged from the latched fields, so an empty nest spends one cycle in RUN
    always_comb begin
        state_nx   = state;
        insn_ready = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                insn_ready = 1'b1;
                if (insn_valid) state_nx = RUN;
            end
            RUN: begin
                if (empty) state_nx = FIN;
                else if (issue && u_wrap && i_wrap && o_wrap) state_nx = DRAIN;
            end
            DRAIN: if (idx_valid && idx_ready && idx_last) state_nx = FIN;
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            insn_ready = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s1_vld    <= 1'b0;
            s1_fresh  <= 1'b0;
            idx_valid <= 1'b0;
            dst_idx   <= '0;
            src_idx   <= '0;
            wgt_idx   <= '0;
            idx_reset <= 1'b0;
            idx_last  <= 1'b0;
            idx_err   <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == IDLE && insn_valid) begin
                rr       <= insn[7];
                u_bgn    <= {1'b0, insn[20:8]};
                u_end    <= insn[34:21];
                n_out    <= insn[48:35];
                n_in     <= insn[62:49];
                f_out[0] <= SW'(insn[73:63]);
                f_in[0]  <= SW'(insn[84:74]);
                f_out[1] <= SW'(insn[95:85]);
                f_in[1]  <= SW'(insn[106:96]);
                f_out[2] <= SW'(insn[116:107]);
                f_in[2]  <= SW'(insn[126:117]);
                empty    <= (insn[48:35] == '0) || (insn[62:49] == '0) ||
                            (insn[34:21] <= {1'b0, insn[20:8]});
                u        <= {1'b0, insn[20:8]};
                o        <= '0;
                i        <= '0;
                base_o   <= '0;
                base     <= '0;
                idx_err  <= 1'b0;
            end

            // loop counters; base tracks o*f_out + i*f_in incrementally
            if (issue) begin
                if (!u_wrap) begin
                    u <= u + 14'd1;
                end else begin
                    u <= u_bgn;
                    if (!i_wrap) begin
                        i <= i + 14'd1;
                        for (int k = 0; k < 3; k++) base[k] <= base[k] + f_in[k];
                    end else begin
                        i <= '0;
                        o <= o + 14'd1;
                        for (int k = 0; k < 3; k++) begin
                            base_o[k] <= base_o[k] + f_out[k];
                            base[k]   <= base_o[k] + f_out[k];
                        end
                    end
                end
            end

            // S1: bases travel with the read; data lands the following cycle
            s1_fresh <= issue;
            if (s1_fresh) s1_data <= uop_data;
            if (issue) begin
                s1_vld  <= 1'b1;
                s1_base <= base;
                s1_last <= u_wrap && i_wrap && o_wrap;
            end else if (s2_en) begin
                s1_vld <= 1'b0;
            end

            // S2: output register
            if (s2_en) begin
                idx_valid <= s1_vld;
                if (s1_vld) begin
                    dst_idx   <= sum[0][ACC_W-1:0];
                    src_idx   <= sum[1][INP_W-1:0];
                    wgt_idx   <= sum[2][WGT_W-1:0];
                    idx_reset <= rr;
                    idx_last  <= s1_last;
                    if (err_hit) idx_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gemm_idx_gen.sv
// Randomized bench for gemm_idx_gen: nested-loop reference model, per-cycle compare process.
module tb_gemm_idx_gen;
    localparam int ACC_W = 11, INP_W = 11, WGT_W = 10, UOP_AW = 13;
`ifdef GEMM_IDX_BOUND_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic              clk = 1'b0, rst = 1'b1;
    logic              insn_valid = 1'b0, insn_ready;
    logic [127:0]      insn = '0;
    logic              uop_rd_en;
    logic [UOP_AW-1:0] uop_addr;
    logic [31:0]       uop_data = '0;
    logic              idx_valid, idx_ready = 1'b1;
    logic [ACC_W-1:0]  dst_idx;
    logic [INP_W-1:0]  src_idx;
    logic [WGT_W-1:0]  wgt_idx;
    logic              idx_reset, idx_last, done, idx_err;

    gemm_idx_gen #(.ACC_W(ACC_W), .INP_W(INP_W), .WGT_W(WGT_W), .UOP_AW(UOP_AW)) dut (
        .clk(clk), .rst(rst), .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn),
        .uop_rd_en(uop_rd_en), .uop_addr(uop_addr), .uop_data(uop_data),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .dst_idx(dst_idx), .src_idx(src_idx),
        .wgt_idx(wgt_idx), .idx_reset(idx_reset), .idx_last(idx_last), .done(done),
        .idx_err(idx_err));

    always #5 clk = ~clk;

    typedef struct { int dst; int src; int wgt; bit rr; bit last; } trip_t;
    trip_t q[$];
    logic [31:0] mem [0:(1<<UOP_AW)-1];

    int total = 0, bad = 0, cyc = 0;
    int done_cnt = 0, done_due = -1, hs_cyc = -1, first_v = -1, rd_cnt = 0, acc_cnt = 0;
    int last_dst = -1, last_src = -1, last_wgt = -1, last_acc_cyc = -1, n_exp = 0;
    bit model_err = 1'b0, rdy_rand = 1'b0, stalled = 1'b0;
    logic [31:0] p_data;
    logic [1:0]  p_flags;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // synchronous uop memory; garbage when not read so held data must come from the DUT
    always @(posedge clk) uop_data <= uop_rd_en ? mem[uop_addr] : $urandom();
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        idx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // compare process
    always @(negedge clk) begin
        trip_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (uop_rd_en) rd_cnt++;
            if (stalled) begin
                chk("stall_valid", 32'(idx_valid), 32'd1);
                chk("stall_data", {dst_idx, src_idx, wgt_idx}, p_data);
                chk("stall_flags", 32'({idx_last, idx_reset}), 32'(p_flags));
            end
            if (idx_valid && first_v < 0) first_v = cyc;
            if (idx_valid && idx_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_triple: got dst=%0d with none expected", dst_idx);
                end else begin
                    e = q.pop_front();
                    chk("dst", 32'(dst_idx), e.dst);
                    chk("src", 32'(src_idx), e.src);
                    chk("wgt", 32'(wgt_idx), e.wgt);
                    chk("reset_bit", 32'(idx_reset), 32'(e.rr));
                    chk("last_bit", 32'(idx_last), 32'(e.last));
                    acc_cnt++;
                    last_dst = dst_idx;
                    last_src = src_idx;
                    last_wgt = wgt_idx;
                    last_acc_cyc = cyc;
                    if (e.last) done_due = cyc + 1;
                end
            end
            stalled = idx_valid && !idx_ready;
            p_data  = {dst_idx, src_idx, wgt_idx};
            p_flags = {idx_last, idx_reset};
            if (done) begin
                done_cnt++;
                chk("done_cycle", cyc, done_due);
                done_due = -1;
            end
        end
    end

    function automatic logic [127:0] mk(input bit rr, input int ub, input int ue, input int io,
                                        input int ii, input int dof, input int dif,
                                        input int sof, input int sif, input int wof,
                                        input int wif);
        logic [127:0] w;
        w          = '0;
        w[6:0]     = 7'h5a;
        w[7]       = rr;
        w[20:8]    = 13'(ub);
        w[34:21]   = 14'(ue);
        w[48:35]   = 14'(io);
        w[62:49]   = 14'(ii);
        w[73:63]   = 11'(dof);
        w[84:74]   = 11'(dif);
        w[95:85]   = 11'(sof);
        w[106:96]  = 11'(sif);
        w[116:107] = 10'(wof);
        w[126:117] = 10'(wif);
        w[127]     = 1'b1;
        return w;
    endfunction

    // call at a negedge; builds the expected triples then performs the handshake
    task automatic send(input logic [127:0] w);
        int n = 0;
        int ub = int'(w[20:8]), ue = int'(w[34:21]), io = int'(w[48:35]), ii = int'(w[62:49]);
        int dof = int'(w[73:63]), dif = int'(w[84:74]), sof = int'(w[95:85]);
        int sif = int'(w[106:96]), wof = int'(w[116:107]), wif = int'(w[126:117]);
        trip_t e;
        while (!insn_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!insn_ready) begin
            total++;
            bad++;
            $display("FAIL insn_ready_timeout: got 0 want 1");
        end
        model_err = 1'b0;
        n_exp = 0;
        for (int o = 0; o < io; o++)
            for (int i = 0; i < ii; i++)
                for (int u = ub; u < ue; u++) begin
                    int d = o * dof + i * dif + int'(mem[u][10:0]);
                    int s = o * sof + i * sif + int'(mem[u][21:11]);
                    int g = o * wof + i * wif + int'(mem[u][31:22]);
                    e.dst  = d % (1 << ACC_W);
                    e.src  = s % (1 << INP_W);
                    e.wgt  = g % (1 << WGT_W);
                    e.rr   = w[7];
                    e.last = (o == io - 1) && (i == ii - 1) && (u == ue - 1);
                    if (BC && (d >= (1 << ACC_W) || s >= (1 << INP_W) || g >= (1 << WGT_W)))
                        model_err = 1'b1;
                    q.push_back(e);
                    n_exp++;
                end
        insn = w;
        insn_valid = 1'b1;
        hs_cyc = cyc;
        first_v = -1;
        rd_cnt = 0;
        acc_cnt = 0;
        if (n_exp == 0) done_due = cyc + 2;
        @(negedge clk);
        insn_valid = 1'b0;
        insn = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic finish_insn(input string nm);
        int start = done_cnt - 0;
        int n = 0;
        if (done_cnt > 0 && done_due < 0 && n_exp == 0) start = done_cnt;
        while (done_cnt == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got no done want one", nm);
        end
        repeat (3) @(negedge clk);
        chk({nm, "_done_once"}, done_cnt, start + 1);
        chk({nm, "_left"}, q.size(), 0);
        chk({nm, "_reads"}, rd_cnt, n_exp);
        chk({nm, "_triples"}, acc_cnt, n_exp);
        chk({nm, "_err"}, 32'(idx_err), 32'(model_err));
    endtask

    task automatic send_rand(input int ub, input int len, input int io, input int ii);
        for (int k = ub; k < ub + len; k++) mem[k] = $urandom();
        send(mk(1'($urandom_range(0, 1)), ub, ub + len, io, ii,
                $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                $urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, 1023)));
    endtask

    initial begin
        for (int k = 0; k < (1 << UOP_AW); k++) mem[k] = $urandom();
        repeat (2) @(negedge clk);
        chk("rst_insn_ready", 32'(insn_ready), 0);
        chk("rst_valid", 32'(idx_valid), 0);
        chk("rst_rd_en", 32'(uop_rd_en), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_insn_ready", 32'(insn_ready), 1);
        chk("post_rst_outs", 32'({uop_rd_en, idx_valid, idx_reset, idx_last, done, idx_err}), 0);
        chk("post_rst_idx", {dst_idx, src_idx, wgt_idx}, 0);
        chk("post_rst_addr", 32'(uop_addr), 0);

        // 2x3 nest over two zero uops
        mem[0] = '0;
        mem[1] = '0;
        send(mk(1'b1, 0, 2, 2, 3, 8, 2, 4, 1, 1, 0));
        finish_insn("basic");
        chk("basic_count", acc_cnt, 12);
        chk("basic_last_dst", last_dst, 12);
        chk("basic_last_src", last_src, 6);
        chk("basic_last_wgt", last_wgt, 1);
        chk("basic_latency", first_v - hs_cyc, 3);
        chk("basic_throughput", last_acc_cyc - first_v, 11);

        // empty nests
        send(mk(1'b0, 5, 5, 2, 2, 1, 1, 1, 1, 1, 1));
        finish_insn("empty_uop");
        chk("empty_no_valid", first_v, -1);
        send(mk(1'b0, 3, 9, 4, 0, 1, 1, 1, 1, 1, 1));
        finish_insn("empty_iter");

        // 64 triples under random backpressure
        rdy_rand = 1'b1;
        send_rand(10, 8, 2, 4);
        finish_insn("bp64");
        chk("bp64_count", acc_cnt, 64);
        for (int t = 0; t < 4; t++) begin
            send_rand($urandom_range(0, 8000), $urandom_range(1, 6), $urandom_range(1, 3),
                      $urandom_range(1, 4));
            finish_insn("rand");
        end
        rdy_rand = 1'b0;

        // overflow on o=1: 2047 + acc 1 wraps to 0
        mem[20] = 32'd1;
        send(mk(1'b0, 20, 21, 2, 1, 2047, 0, 0, 0, 0, 0));
        finish_insn("bound");
        chk("bound_flag", 32'(idx_err), 32'(BC));
        chk("bound_last_dst", last_dst, 0);
        send(mk(1'b0, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0));
        chk("err_cleared", 32'(idx_err), 0);
        finish_insn("clear");

        // reset in the middle of a long run
        for (int k = 0; k < 8; k++) mem[k] = $urandom();
        send(mk(1'b1, 0, 8, 4, 4, 3, 5, 7, 11, 13, 17));
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        done_due = -1;
        @(negedge clk);
        chk("midrst_insn_ready", 32'(insn_ready), 1);
        chk("midrst_outs", 32'({uop_rd_en, idx_valid, idx_reset, idx_last, done, idx_err}), 0);
        chk("midrst_idx", {dst_idx, src_idx, wgt_idx}, 0);
        rdy_rand = 1'b1;
        send_rand(100, 5, 3, 2);
        finish_insn("after_rst");
        rdy_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
